muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Sequencer and owner of the HI/LO architectural registers for MIPS mult/multu/div/divu/mthi/mtlo.
- Sits beside the execute stage. It takes single-cycle issue pulses, drives an external pipelined multiplier (fixed latency) and an external iterative divider (start/done handshake), and writes results into HI/LO.
- Raises busy so the pipeline stalls mfhi/mflo and further mul/div ops.
- Cancels in-flight work on an exception flush.

Parameters:
- MUL_LAT, 3: multiplier latency in cycles from mul_start to valid mul_res; legal range 1..8.

Ports:
- Clk  in  1  clock; all logic on posedge.
- Clr_n  in  1  synchronous active-low reset.
- op_valid  in  1  single-cycle issue pulse from execute.
- op_code  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6/7 reserved.
- op_a  in  32  rs operand, already forwarded.
- op_b  in  32  rt operand, already forwarded.
- flush  in  1  exception/ERET flush; cancels everything in flight.
- busy  out  1  high while a mul/div is in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_signed  out  1  signed multiply select.
- mul_a  out  32  registered multiplier operand.
- mul_b  out  32  registered multiplier operand.
- mul_res  in  64  multiplier product, valid MUL_LAT cycles after mul_start.
- div_start  out  1  one-cycle start pulse to the divider.
- div_signed  out  1  signed divide select.
- div_a  out  32  registered divider operand.
- div_b  out  32  registered divider operand.
- div_done  in  1  one-cycle completion pulse from the divider.
- div_quo  in  32  quotient, valid with div_done.
- div_rem  in  32  remainder, valid with div_done.
- div_abort  out  1  one-cycle pulse telling the divider to drop its operation.

Behaviour:
- Reset (Clr_n=0 at posedge), regardless of state:
  - state=IDLE; hi=lo=0; cnt=0.
  - busy, mul_start, div_start, div_abort = 0; mul_signed=div_signed=0.
  - mul_a/mul_b/div_a/div_b = 0.
  - Reset mid-operation does not pulse div_abort; the divider shares the reset.
- States: IDLE, MUL, DIV. busy = (state != IDLE), registered.
- All outputs are registered. start and abort pulses last exactly one cycle.
- In IDLE with op_valid=1 and flush=0:
  - mthi: hi<=op_a next edge; stay IDLE; busy stays 0.
  - mtlo: lo<=op_a next edge; stay IDLE; busy stays 0.
  - mult/multu: latch mul_a/mul_b=op_a/op_b; mul_signed=(op_code==0); mul_start=1 for one cycle; cnt<=MUL_LAT-1; go to MUL.
  - div/divu with op_b!=0: latch div_a/div_b; div_signed=(op_code==2); div_start=1 for one cycle; go to DIV.
  - div/divu with op_b==0: no start; stay IDLE; hi/lo unchanged (result architecturally undefined).
  - op_code 6/7: ignored.
- MUL:
  - cnt decrements each cycle.
  - When cnt==0: {hi,lo}<=mul_res; go to IDLE.
  - busy falls on the same edge hi/lo update, so the first non-busy cycle sees the new values.
  - Total busy = MUL_LAT cycles.
  - MUL_LAT=1: the first MUL cycle is the writeback cycle.
- DIV:
  - Wait for div_done. On div_done: lo<=div_quo, hi<=div_rem; go to IDLE.
  - No timeout.
  - Signed overflow (0x80000000 / -1) is passed through unmodified; the divider defines the result.
- flush:
  - flush=1 in MUL: go to IDLE; no writeback, even if cnt==0 that cycle (flush wins).
  - flush=1 in DIV: div_abort=1 for one cycle; go to IDLE; no writeback, even with coincident div_done.
  - flush=1 in IDLE with op_valid: op dropped, including mthi/mtlo; no start pulse.
- op_valid while busy=1 is a protocol violation; it is ignored and HI/LO are unaffected. The pipeline guarantees this by stalling on busy.
- div_done while not in DIV is ignored.
- Back-to-back: a new op may be issued in the first cycle busy=0. The mthi/mtlo write is visible on hi/lo the cycle after issue.

Test Plan:
- Reset then idle -> hi=lo=0, busy=0; no start pulses for 10 cycles.
- mthi op_a=0x12345678, next cycle mtlo op_a=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0; busy never asserted.
- MUL_LAT=3, mult op_a=0xFFFFFFFE (-2), op_b=3:
  - mul_start pulses once with mul_signed=1.
  - busy high exactly 3 cycles.
  - Model returns 0xFFFFFFFF_FFFFFFFA -> hi=0xFFFFFFFF, lo=0xFFFFFFFA when busy falls.
  - Repeat as multu -> mul_signed=0.
- divu 100/7, div_done after 33 cycles with quo=14, rem=2 -> lo=14, hi=2; busy high 33 cycles. div op_b=0 -> no div_start, hi/lo unchanged, busy 0.
- flush during DIV on the same cycle as div_done -> div_abort one-cycle pulse, hi/lo keep prior values, IDLE next cycle. flush during MUL at cnt==0 -> no writeback.
- Clr_n low mid-MUL -> next cycle state IDLE, hi=lo=0, busy=0; the later mul_res value is ignored.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// Handshake/bus bundle for muldiv_ctrl.
//   Issue side : op_valid, op_code, op_a, op_b, flush -> busy, hi, lo
//   Multiplier : mul_start, mul_signed, mul_a, mul_b  <- mul_res
//   Divider    : div_start, div_signed, div_a, div_b, div_abort
//                <- div_done, div_quo, div_rem
// slave  : the controller's view.
// master : the view of the surrounding pipeline and arithmetic units.
interface muldiv_ctrl_if;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mul_start;
    logic        mul_signed;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_res;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic        div_abort;

    modport slave (
        input  op_valid, op_code, op_a, op_b, flush, mul_res,
               div_done, div_quo, div_rem,
        output busy, hi, lo, mul_start, mul_signed, mul_a, mul_b,
               div_start, div_signed, div_a, div_b, div_abort
    );

    modport master (
        output op_valid, op_code, op_a, op_b, flush, mul_res,
               div_done, div_quo, div_rem,
        input  busy, hi, lo, mul_start, mul_signed, mul_a, mul_b,
               div_start, div_signed, div_a, div_b, div_abort
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and sequencer for MIPS mult/multu/div/divu/mthi/mtlo.
// Drives a fixed-latency pipelined multiplier and an iterative divider
// (start/done), writes results into HI/LO and holds busy while a mul/div
// is in flight. flush cancels in-flight work (divider gets div_abort).
// Ports:
//   Clk   : clock, posedge
//   Clr_n : synchronous active-low reset
//   bus   : muldiv_ctrl_if.slave (issue, HI/LO, multiplier, divider)
// Parameter MUL_LAT (1..8): cycles from mul_start to the writeback edge.
module muldiv_ctrl #(
    parameter int MUL_LAT = 3
) (
    input logic          Clk,
    input logic          Clr_n,
    muldiv_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t      state;
    logic [2:0]  cnt;
    logic        busy;
    logic [31:0] hi, lo;
    logic        mul_start, mul_signed;
    logic [31:0] mul_a, mul_b;
    logic        div_start, div_signed, div_abort;
    logic [31:0] div_a, div_b;

    always_ff @(posedge Clk) begin
        if (!Clr_n) begin
            // Divider shares this reset, so no abort pulse here.
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            mul_start  <= 1'b0;
            mul_signed <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            div_start  <= 1'b0;
            div_signed <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
            div_abort  <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            div_start <= 1'b0;
            div_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.op_valid && !bus.flush) begin
                        case (bus.op_code)
                            OP_MTHI: hi <= bus.op_a;
                            OP_MTLO: lo <= bus.op_a;
                            OP_MULT, OP_MULTU: begin
                                mul_a      <= bus.op_a;
                                mul_b      <= bus.op_b;
                                mul_signed <= (bus.op_code == OP_MULT);
                                mul_start  <= 1'b1;
                                cnt        <= 3'(MUL_LAT - 1);
                                state      <= MUL;
                                busy       <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                // Divide by zero: result undefined, leave HI/LO alone.
                                if (bus.op_b != '0) begin
                                    div_a      <= bus.op_a;
                                    div_b      <= bus.op_b;
                                    div_signed <= (bus.op_code == OP_DIV);
                                    div_start  <= 1'b1;
                                    state      <= DIV;
                                    busy       <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    // flush takes priority over a same-cycle writeback.
                    if (bus.flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == '0) begin
                        {hi, lo} <= bus.mul_res;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DIV: begin
                    if (bus.flush) begin
                        div_abort <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else if (bus.div_done) begin
                        lo    <= bus.div_quo;
                        hi    <= bus.div_rem;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy;
    assign bus.hi         = hi;
    assign bus.lo         = lo;
    assign bus.mul_start  = mul_start;
    assign bus.mul_signed = mul_signed;
    assign bus.mul_a      = mul_a;
    assign bus.mul_b      = mul_b;
    assign bus.div_start  = div_start;
    assign bus.div_signed = div_signed;
    assign bus.div_a      = div_a;
    assign bus.div_b      = div_b;
    assign bus.div_abort  = div_abort;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, hand-written
// flush/reset sequences and randomized ops against an arithmetic model.
module tb_muldiv_ctrl;
    localparam int L = 3;

    logic Clk = 1'b0;
    logic Clr_n = 1'b0;
    always #5 Clk = ~Clk;

    muldiv_ctrl_if bus();
    muldiv_ctrl #(.MUL_LAT(L)) dut (.Clk(Clk), .Clr_n(Clr_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Multiplier: product presented only in the cycle the controller
    // should write back; garbage at any other time.
    int unsigned mage = 100;
    logic [63:0] xa, xb, prod;
    logic        mvalid;
    always @(posedge Clk) begin
        if (bus.mul_start) mage <= 1;
        else if (mage < 100) mage <= mage + 1;
    end
    always_comb begin
        xa = '0;
        xb = '0;
        prod = '0;
        if (bus.mul_signed) begin
            xa = {{32{bus.mul_a[31]}}, bus.mul_a};
            xb = {{32{bus.mul_b[31]}}, bus.mul_b};
        end else begin
            xa = {32'b0, bus.mul_a};
            xb = {32'b0, bus.mul_b};
        end
        prod = xa * xb;
    end
    assign mvalid = (L == 1) ? bus.mul_start : (mage == L - 1);
    assign bus.mul_res = mvalid ? prod : 64'hDEAD_BEEF_0BAD_F00D;

    // Divider: done pulses dlat cycles after start (counting the start cycle).
    int   dlat = 33;
    int   dcnt = 0;
    logic force_done = 1'b0;
    always @(posedge Clk) begin
        if (!Clr_n || bus.div_abort) dcnt <= 0;
        else if (bus.div_start) dcnt <= dlat - 1;
        else if (dcnt > 0) dcnt <= dcnt - 1;
    end
    assign bus.div_done = (dcnt == 1) || force_done;
    always_comb begin
        bus.div_quo = '0;
        bus.div_rem = '0;
        if (bus.div_b != '0) begin
            if (bus.div_signed) begin
                bus.div_quo = $signed(bus.div_a) / $signed(bus.div_b);
                bus.div_rem = $signed(bus.div_a) % $signed(bus.div_b);
            end else begin
                bus.div_quo = bus.div_a / bus.div_b;
                bus.div_rem = bus.div_a % bus.div_b;
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Issue one op (caller sits just after a posedge) and follow it until idle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int bcyc, output int ms, output int ds,
                          output logic msig, output logic dsig);
        bus.op_valid = 1'b1;
        bus.op_code  = op;
        bus.op_a     = a;
        bus.op_b     = b;
        step();
        bus.op_valid = 1'b0;
        ms   = int'(bus.mul_start);
        ds   = int'(bus.div_start);
        msig = bus.mul_signed;
        dsig = bus.div_signed;
        bcyc = 0;
        while (bus.busy && bcyc < 500) begin
            bcyc++;
            step();
            ms += int'(bus.mul_start);
            ds += int'(bus.div_start);
        end
    endtask

    // Architectural model: HI/LO effect, busy duration and start counts.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input int dl, inout logic [31:0] h, inout logic [31:0] l,
                                  output int bc, output int ms, output int ds);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        bc = 0; ms = 0; ds = 0;
        sa = a; sb = b;
        case (op)
            3'd0: begin sp = longint'(sa) * longint'(sb); {h, l} = sp; bc = L; ms = 1; end
            3'd1: begin up = longint'({32'b0, a}) * longint'({32'b0, b}); {h, l} = up; bc = L; ms = 1; end
            3'd2: if (b != 0) begin l = sa / sb; h = sa % sb; bc = dl; ds = 1; end
            3'd3: if (b != 0) begin l = a / b; h = a % b; bc = dl; ds = 1; end
            3'd4: h = a;
            3'd5: l = a;
            default: ;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          dl;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          ebusy;
        int          ems;
        int          eds;
        logic        esig;
    } vec_t;

    vec_t vt[9];

    initial begin
        int          bc, ms, ds, ebc, ems, eds, st;
        logic        msig, dsig;
        logic [31:0] mh, ml, ra, rb;
        logic [2:0]  rop;

        vt[0] = '{3'd4, 32'h12345678, 32'h0, 2, 32'h12345678, 32'h0,        0,  0, 0, 1'b0};
        vt[1] = '{3'd5, 32'h9ABCDEF0, 32'h0, 2, 32'h12345678, 32'h9ABCDEF0, 0,  0, 0, 1'b0};
        vt[2] = '{3'd0, 32'hFFFFFFFE, 32'h3, 2, 32'hFFFFFFFF, 32'hFFFFFFFA, L,  1, 0, 1'b1};
        vt[3] = '{3'd1, 32'hFFFFFFFE, 32'h3, 2, 32'h00000002, 32'hFFFFFFFA, L,  1, 0, 1'b0};
        vt[4] = '{3'd3, 32'd100,      32'd7, 33, 32'd2,       32'd14,       33, 0, 1, 1'b0};
        vt[5] = '{3'd2, 32'd5,        32'd0, 2, 32'd2,        32'd14,       0,  0, 0, 1'b0};
        vt[6] = '{3'd2, 32'hFFFFFF9C, 32'd7, 4, 32'hFFFFFFFE, 32'hFFFFFFF2, 4,  0, 1, 1'b1};
        vt[7] = '{3'd6, 32'h1,        32'h1, 2, 32'hFFFFFFFE, 32'hFFFFFFF2, 0,  0, 0, 1'b0};
        vt[8] = '{3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 2, 32'h3FFFFFFF, 32'h00000001, L, 1, 0, 1'b1};

        bus.op_valid = 1'b0;
        bus.op_code  = '0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.flush    = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_starts", {bus.mul_start, bus.div_start, bus.div_abort}, 0);
        Clr_n = 1'b1;
        st = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            st += int'(bus.mul_start) + int'(bus.div_start) + int'(bus.busy);
        end
        check("idle_quiet", st, 0);

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            dlat = vt[i].dl;
            run_op(vt[i].op, vt[i].a, vt[i].b, bc, ms, ds, msig, dsig);
            check($sformatf("vec%0d_hi", i), bus.hi, vt[i].ehi);
            check($sformatf("vec%0d_lo", i), bus.lo, vt[i].elo);
            check($sformatf("vec%0d_busy", i), bc, vt[i].ebusy);
            check($sformatf("vec%0d_mstart", i), ms, vt[i].ems);
            check($sformatf("vec%0d_dstart", i), ds, vt[i].eds);
            if (vt[i].ems != 0) check($sformatf("vec%0d_msig", i), msig, vt[i].esig);
            if (vt[i].eds != 0) check($sformatf("vec%0d_dsig", i), dsig, vt[i].esig);
        end
        mh = bus.hi;
        ml = bus.lo;

        // flush in DIV on the same cycle as div_done
        dlat = 5;
        bus.op_valid = 1'b1; bus.op_code = 3'd3; bus.op_a = 32'd50; bus.op_b = 32'd3;
        step();
        bus.op_valid = 1'b0;
        repeat (4) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("dflush_abort", bus.div_abort, 1);
        check("dflush_busy", bus.busy, 0);
        check("dflush_hilo", {bus.hi, bus.lo}, {mh, ml});
        step();
        check("dflush_abort_1cyc", bus.div_abort, 0);
        check("dflush_hilo2", {bus.hi, bus.lo}, {mh, ml});

        // flush in MUL at the writeback cycle
        bus.op_valid = 1'b1; bus.op_code = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd5;
        step();
        bus.op_valid = 1'b0;
        repeat (L - 1) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("mflush_busy", bus.busy, 0);
        check("mflush_hilo", {bus.hi, bus.lo}, {mh, ml});
        repeat (3) step();
        check("mflush_hilo2", {bus.hi, bus.lo}, {mh, ml});

        // flush in IDLE drops mthi and mult
        bus.flush = 1'b1; bus.op_valid = 1'b1; bus.op_code = 3'd4; bus.op_a = 32'hAAAA5555;
        step();
        check("iflush_mthi", bus.hi, mh);
        bus.op_code = 3'd0;
        step();
        bus.flush = 1'b0; bus.op_valid = 1'b0;
        check("iflush_mult", {bus.mul_start, bus.busy}, 0);

        // stray div_done in IDLE
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        check("stray_done", {bus.hi, bus.lo, bus.busy}, {mh, ml, 1'b0});

        // reset mid-MUL; later product must be ignored
        bus.op_valid = 1'b1; bus.op_code = 3'd1; bus.op_a = 32'h10000; bus.op_b = 32'h10000;
        step();
        bus.op_valid = 1'b0;
        Clr_n = 1'b0;
        step();
        Clr_n = 1'b1;
        check("rstmul_state", {bus.busy, bus.hi, bus.lo}, 0);
        repeat (5) step();
        check("rstmul_after", {bus.busy, bus.hi, bus.lo}, 0);

        // Randomized ops against the model
        mh = bus.hi;
        ml = bus.lo;
        for (int i = 0; i < 60; i++) begin
            rop  = 3'($urandom_range(0, 7));
            ra   = $urandom;
            rb   = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'h80000000;
            if (rop == 3'd2 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'h1;
            dlat = $urandom_range(2, 12);
            model(rop, ra, rb, dlat, mh, ml, ebc, ems, eds);
            run_op(rop, ra, rb, bc, ms, ds, msig, dsig);
            check($sformatf("rnd%0d_op%0d_hi", i, rop), bus.hi, mh);
            check($sformatf("rnd%0d_op%0d_lo", i, rop), bus.lo, ml);
            check($sformatf("rnd%0d_op%0d_busy", i, rop), bc, ebc);
            check($sformatf("rnd%0d_op%0d_starts", i, rop), {ms[7:0], ds[7:0]}, {ems[7:0], eds[7:0]});
            mh = bus.hi;
            ml = bus.lo;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
